// File: rtl/rv32i_rf_alu.sv
// RV32I integer datapath slice: 32x32 register file (2R/1W) and a combinational OP/OP-IMM ALU.
// Define RF_BYPASS_EN to forward same-cycle write data to a matching read port.
module rv32i_rf_alu #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  reg1_address,
  input  logic [4:0]  reg2_address,
  input  logic        write_enable,
  input  logic [4:0]  write_address,
  input  logic [31:0] write_data,
  output logic [31:0] reg1_data,
  output logic [31:0] reg2_data,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  input  logic [4:0]  shamt,
  output logic [31:0] alu_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // x0 has no storage; it is hardwired to zero on both read ports.
  logic [31:0] regs [1:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= REG_RESET_VAL;
    end else if (write_enable && (write_address != 5'd0)) begin
      regs[write_address] <= write_data;
    end
  end

  always_comb begin
    reg1_data = '0;
    if (reg1_address != 5'd0) reg1_data = regs[reg1_address];
`ifdef RF_BYPASS_EN
    if (write_enable && (write_address != 5'd0) && (reg1_address == write_address))
      reg1_data = write_data;
`endif
  end

  always_comb begin
    reg2_data = '0;
    if (reg2_address != 5'd0) reg2_data = regs[reg2_address];
`ifdef RF_BYPASS_EN
    if (write_enable && (write_address != 5'd0) && (reg2_address == write_address))
      reg2_data = write_data;
`endif
  end

  logic               is_op;
  logic               is_op_imm;
  logic        [31:0] op_b;
  logic        [4:0]  sh;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] sra_s;

  // Only funct7[5] distinguishes operations; the remaining bits are don't-care.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    is_op     = (opcode == OPC_OP);
    is_op_imm = (opcode == OPC_OP_IMM);
    op_b      = is_op_imm ? {{20{imm[11]}}, imm} : reg2_data;
    sh        = is_op_imm ? shamt : reg2_data[4:0];
    a_s       = reg1_data;
    b_s       = op_b;
    sra_s     = a_s >>> sh;
  end

  always_comb begin
    alu_out = '0;
    if (is_op || is_op_imm) begin
      case (funct3)
        3'b000:  alu_out = (is_op && funct7[5]) ? (reg1_data - op_b) : (reg1_data + op_b);
        3'b001:  alu_out = reg1_data << sh;
        3'b010:  alu_out = {31'd0, (a_s < b_s)};
        3'b011:  alu_out = {31'd0, (reg1_data < op_b)};
        3'b100:  alu_out = reg1_data ^ op_b;
        3'b101:  alu_out = funct7[5] ? sra_s : (reg1_data >> sh);
        3'b110:  alu_out = reg1_data | op_b;
        default: alu_out = reg1_data & op_b;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_rf_alu.sv
// Scoreboard bench for rv32i_rf_alu: directed vectors push expectations, a negedge monitor checks them.
module tb_rv32i_rf_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg1_address, reg2_address, write_address;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] reg1_data, reg2_data, alu_out;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [4:0]  shamt;

  rv32i_rf_alu dut (
    .clk(clk), .reset(reset),
    .reg1_address(reg1_address), .reg2_address(reg2_address),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm), .shamt(shamt),
    .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  localparam int P_ALU = 0, P_RD1 = 1, P_RD2 = 2;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: outputs are sampled at the falling edge, between active edges.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.port)
          P_RD1:   act = reg1_data;
          P_RD2:   act = reg2_data;
          default: act = alu_out;
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string name, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.port = port; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step();
    write_enable = 1'b1; write_address = a; write_data = d;
    step();
    write_enable = 1'b0;
  endtask

  task automatic alu(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [11:0] im, input logic [4:0] sa,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] exp);
    step();
    opcode = opc; funct3 = f3; funct7 = f7; imm = im; shamt = sa;
    reg1_address = r1; reg2_address = r2;
    expect_v(name, P_ALU, exp);
    settle();
  endtask

  initial begin
    reset = 1'b1;
    reg1_address = 5'd5; reg2_address = 5'd31;
    write_enable = 1'b0; write_address = '0; write_data = '0;
    opcode = '0; funct3 = '0; funct7 = '0; imm = '0; shamt = '0;
    expect_v("reset_x5", P_RD1, 32'h0);
    expect_v("reset_x31", P_RD2, 32'h0);
    settle();
    step();
    reset = 1'b0;

    // Asynchronous reset between edges
    wr(5'd5, 32'hDEADBEEF);
    reg1_address = 5'd5;
    expect_v("write_x5", P_RD1, 32'hDEADBEEF);
    settle();
    step();
    reset = 1'b1;
    expect_v("async_reset_x5", P_RD1, 32'h0);
    settle();
    step();
    reset = 1'b0;

    wr(5'd0, 32'h1234);
    reg1_address = 5'd0;
    expect_v("x0_stays_zero", P_RD1, 32'h0);
    settle();

    // OP-IMM on x1 = 0xFFFFFFF0
    wr(5'd1, 32'hFFFF_FFF0);
    alu("addi",   OPI, 3'b000, 7'b0000000, 12'h010, 5'd0, 5'd1, 5'd0, 32'h0000_0000);
    alu("slti",   OPI, 3'b010, 7'b0000000, 12'h000, 5'd0, 5'd1, 5'd0, 32'h0000_0001);
    alu("sltiu",  OPI, 3'b011, 7'b0000000, 12'hFFF, 5'd0, 5'd1, 5'd0, 32'h0000_0001);
    alu("srai",   OPI, 3'b101, 7'b0100000, 12'h404, 5'd4, 5'd1, 5'd0, 32'hFFFF_FFFF);
    alu("srli",   OPI, 3'b101, 7'b0000000, 12'h004, 5'd4, 5'd1, 5'd0, 32'h0FFF_FFFF);
    alu("xori",   OPI, 3'b100, 7'b0000000, 12'h0FF, 5'd0, 5'd1, 5'd0, 32'hFFFF_FF0F);
    alu("ori",    OPI, 3'b110, 7'b0000000, 12'h00F, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFF);
    alu("andi",   OPI, 3'b111, 7'b0000000, 12'h7F0, 5'd0, 5'd1, 5'd0, 32'h0000_07F0);
    alu("slli",   OPI, 3'b001, 7'b0000000, 12'h004, 5'd4, 5'd1, 5'd0, 32'hFFFF_FF00);
    alu("slli_0", OPI, 3'b001, 7'b0000000, 12'h000, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFF0);

    // OP with x2 = 7, x3 = 9
    wr(5'd2, 32'd7);
    wr(5'd3, 32'd9);
    alu("sub",      OP, 3'b000, 7'b0100000, 12'h0, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFE);
    alu("add_f7",   OP, 3'b000, 7'b0000001, 12'h0, 5'd0, 5'd2, 5'd3, 32'h0000_0010);
    alu("slt",      OP, 3'b010, 7'b0000000, 12'h0, 5'd0, 5'd2, 5'd3, 32'h0000_0001);
    alu("sltu",     OP, 3'b011, 7'b0000000, 12'h0, 5'd0, 5'd3, 5'd2, 32'h0000_0000);
    alu("and",      OP, 3'b111, 7'b0000000, 12'h0, 5'd0, 5'd2, 5'd3, 32'h0000_0001);
    alu("or",       OP, 3'b110, 7'b0000000, 12'h0, 5'd0, 5'd2, 5'd3, 32'h0000_000F);
    alu("xor",      OP, 3'b100, 7'b0000000, 12'h0, 5'd0, 5'd2, 5'd3, 32'h0000_000E);

    wr(5'd3, 32'h8000_0000);
    alu("sll_out",  OP, 3'b001, 7'b0000000, 12'h0, 5'd0, 5'd3, 5'd2, 32'h0000_0000);
    alu("sra",      OP, 3'b101, 7'b0100000, 12'h0, 5'd0, 5'd3, 5'd2, 32'hFF00_0000);
    alu("srl",      OP, 3'b101, 7'b0000000, 12'h0, 5'd0, 5'd3, 5'd2, 32'h0100_0000);
    alu("slt_neg",  OP, 3'b010, 7'b0000000, 12'h0, 5'd0, 5'd3, 5'd2, 32'h0000_0001);
    alu("sltu_big", OP, 3'b011, 7'b0000000, 12'h0, 5'd0, 5'd3, 5'd2, 32'h0000_0000);

    wr(5'd4, 32'd33);
    alu("sll_mask", OP, 3'b001, 7'b0000000, 12'h0, 5'd0, 5'd2, 5'd4, 32'h0000_000E);
    alu("non_alu",  LUI, 3'b000, 7'b0000000, 12'hFFF, 5'd1, 5'd2, 5'd3, 32'h0000_0000);

    // Same-cycle read/write of x6
    wr(5'd6, 32'd1);
    step();
    write_enable = 1'b1; write_address = 5'd6; write_data = 32'd2;
    reg1_address = 5'd6; reg2_address = 5'd6;
`ifdef RF_BYPASS_EN
    expect_v("rw_same_pre1", P_RD1, 32'd2);
    expect_v("rw_same_pre2", P_RD2, 32'd2);
`else
    expect_v("rw_same_pre1", P_RD1, 32'd1);
    expect_v("rw_same_pre2", P_RD2, 32'd1);
`endif
    settle();
    step();
    write_enable = 1'b0;
    expect_v("rw_same_post", P_RD1, 32'd2);
    settle();

    step();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_rf_alu.md
Name: rv32i_rf_alu

Overview:
- Integer datapath slice for the single-cycle RV32I core: a 32x32 register file with two read ports and one write port, plus a combinational ALU.
- The ALU executes the OP (0110011) and OP-IMM (0010011) instruction classes.
- The core's control logic supplies decoded instruction fields and the write-back data, and consumes rv1, rv2 and alu_out.

Parameters:
- REG_RESET_VAL, 32'h0000_0000, value loaded into x1..x31 on reset.

Ports:
- clk  input  1  system clock; all register writes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- reg1_address  input  5  read port 1 index (rs1).
- reg2_address  input  5  read port 2 index (rs2).
- write_enable  input  1  register write enable.
- write_address  input  5  write index (rd).
- write_data  input  32  write-back value.
- reg1_data  output  32  combinational read of reg1_address.
- reg2_data  output  32  combinational read of reg2_address.
- opcode  input  7  instruction bits [6:0].
- funct3  input  3  instruction bits [14:12].
- funct7  input  7  instruction bits [31:25].
- imm  input  12  instruction bits [31:20], I-type immediate.
- shamt  input  5  instruction bits [24:20], I-type shift amount.
- alu_out  output  32  combinational ALU result.

Behaviour:
- Reset: asserting reset immediately clears x0 and sets x1..x31 to REG_RESET_VAL, without waiting for a clock edge.
  - Reset dominates write_enable.
  - Deassertion takes effect at the next rising edge.
- Write: on posedge clk with reset low and write_enable=1, reg[write_address] <= write_data.
  - Writes to x0 are ignored; x0 always reads 0.
- Read: reg1_data and reg2_data are purely combinational, with zero latency.
  - A read of the address being written in the same cycle returns the old value (pre-edge), unless RF_BYPASS_EN is defined.
  - Both ports may address the same register.
- The ALU operates on operands A = reg1_data and B. For OP, B = reg2_data. For OP-IMM, B = sign-extended imm.
- OP-IMM (0010011), selected by funct3:
  - 000 ADDI.
  - 010 SLTI: signed compare, result 1/0.
  - 011 SLTIU: unsigned compare of A against the sign-extended imm.
  - 100 XORI.
  - 110 ORI.
  - 111 ANDI.
  - 001 SLLI, by shamt.
  - 101 selects on funct7[5]: 0 gives SRLI, 1 gives SRAI, both by shamt.
- OP (0110011), selected by funct3:
  - 000 selects on funct7[5]: 0 gives ADD, 1 gives SUB.
  - 001 SLL.
  - 010 SLT, signed.
  - 011 SLTU.
  - 100 XOR.
  - 101 selects on funct7[5]: 0 gives SRL, 1 gives SRA.
  - 110 OR.
  - 111 AND.
  - All OP shifts use reg2_data[4:0].
- Arithmetic and width rules:
  - Add/sub wrap modulo 2^32; there is no overflow flag.
  - SRA/SRAI replicate bit 31.
  - A shift amount of 0 passes A through unchanged.
- Other funct7 bits are ignored; the ALU does not trap on illegal encodings.
- Any other opcode: alu_out = 32'h0.
- alu_out depends only on the current inputs: no state, and it is unaffected by clk and reset except through reg1_data and reg2_data.

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined: if write_enable=1, write_address!=0 and a read address equals write_address, that read port returns write_data combinationally in the same cycle.
- When undefined: the read returns the stored value until the clock edge.
- x0 always reads 0 in both configurations.

Test Plan:
- Reset mid-operation:
  - Write x5=0xDEADBEEF, then assert reset between clock edges; reg1_data(x5) reads 0 before the next edge.
  - Write x0=0x1234 with reset low; x0 still reads 0.
- OP-IMM:
  - x1=0xFFFFFFF0 with ADDI imm=0x010 gives 0x00000000.
  - SLTI imm=0x000 gives 1.
  - SLTIU imm=0xFFF gives 1.
  - SRAI shamt=4, funct7=0100000, gives 0xFFFFFFFF.
  - SRLI shamt=4 gives 0x0FFFFFFF.
- OP:
  - x2=7, x3=9: SUB gives 0xFFFFFFFE, SLT(x2,x3)=1, SLTU(x3,x2)=0.
  - x3=0x80000000 with SLL by x2 (shift 7) gives 0x00000000.
  - x2=7 AND x3=9 gives 0x00000001.
- Shift masking: x4=33 used as the shift amount for SLL on x2=7 gives 7<<1 = 0x0000000E.
- Non-ALU opcode 0110111 with any operands gives alu_out=0.
- Same-cycle read/write of x6 (old 1, new 2):
  - Port reads 1 before the edge without RF_BYPASS_EN.
  - Port reads 2 before the edge with RF_BYPASS_EN.
  - Both builds read 2 after the edge.
